// File: rtl/ysyx_24090003_pkg.sv
// Shared constants and types for the ysyx_24090003 core front end.
package ysyx_24090003_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_entry_t;

  function automatic if_id_entry_t mk_entry(input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] inst);
    if_id_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/ysyx_24090003_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read, synchronous clear.
module ysyx_24090003_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge i_clk) begin
    if (i_clr)     mem <= '0;
    else if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/ysyx_24090003_if_id_buf.sv
// IF->ID decoupling FIFO with flush; all handshake outputs registered.
// Optional perf counters enabled by YSYX_24090003_IFID_PERF_EN.
module ysyx_24090003_if_id_buf #(
  parameter int DEPTH = 2,
  parameter int XLEN  = ysyx_24090003_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic [XLEN-1:0] i_in_inst,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_inst,
  input  logic            i_flush
`ifdef YSYX_24090003_IFID_PERF_EN
  ,
  output logic [31:0]     o_stall_cnt,
  output logic [31:0]     o_flush_cnt
`endif
);
  import ysyx_24090003_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * XLEN;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;
  logic [EW-1:0] rdata;

  assign push = i_in_valid && o_in_ready && !i_flush;
  assign pop  = o_out_valid && i_out_ready && !i_flush;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Ready/valid are derived from count_next so both stay pure registers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count       <= count_next;
      o_in_ready  <= count_next < FULL;
      o_out_valid <= count_next != '0;
    end
  end

  ysyx_24090003_fifo_mem #(.DEPTH(DEPTH), .W(EW), .AW(PW)) u_mem (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_we    (push),
    .i_waddr (wptr),
    .i_wdata ({i_in_pc, i_in_inst}),
    .i_raddr (rptr),
    .o_rdata (rdata)
  );

  assign {o_out_pc, o_out_inst} = rdata;

`ifdef YSYX_24090003_IFID_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (i_in_valid && !o_in_ready) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (i_flush)                   o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24090003_if_id_buf.sv
// Randomized bench for ysyx_24090003_if_id_buf against a queue-based FIFO model.
module tb_ysyx_24090003_if_id_buf;
  import ysyx_24090003_pkg::*;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_in_pc = '0;
  logic [31:0] i_in_inst = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_out_pc;
  logic [31:0] o_out_inst;
  logic        i_flush = 1'b0;
`ifdef YSYX_24090003_IFID_PERF_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  always #5 i_clk = ~i_clk;

  ysyx_24090003_if_id_buf #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_pc     (i_in_pc),
    .i_in_inst   (i_in_inst),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_pc    (o_out_pc),
    .o_out_inst  (o_out_inst),
    .i_flush     (i_flush)
`ifdef YSYX_24090003_IFID_PERF_EN
    ,
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
`endif
  );

  // Reference model: a bounded queue plus two event counters.
  if_id_entry_t q[$];
  logic [31:0]  exp_stall = '0;
  logic [31:0]  exp_flush = '0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic tick();
    bit can_push, push, pop;
    can_push = q.size() < DEPTH;
    push = i_in_valid && can_push && !i_flush;
    pop  = (q.size() != 0) && i_out_ready && !i_flush;
    @(posedge i_clk);
    if (i_rst) begin
      q.delete();
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (i_in_valid && !can_push) exp_stall++;
      if (i_flush) begin
        exp_flush++;
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(mk_entry(i_in_pc, i_in_inst));
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_in_valid = 0; i_out_ready = 0; i_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1;
    tick(); tick();
    i_rst = 0;
  endtask

  task automatic fill_two();
    i_out_ready = 0;
    i_in_valid = 1; i_in_pc = RESET_PC;      i_in_inst = 32'h1111_0001; tick();
    i_in_valid = 1; i_in_pc = RESET_PC + 4;  i_in_inst = 32'h1111_0002; tick();
    i_in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", o_out_valid); else n_pass++;
    n_total++; if (o_in_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", o_in_ready); else n_pass++;
    n_total++; if (o_out_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", o_out_pc); else n_pass++;
    n_total++; if (o_out_inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", o_out_inst); else n_pass++;
  endtask

  task automatic test_single_pass();
    i_out_ready = 1;
    i_in_valid = 1; i_in_pc = RESET_PC; i_in_inst = 32'h0000_0413;
    tick();
    i_in_valid = 0;
    n_total++; if (o_out_valid !== 1'b1) $display("FAIL single_valid got=%0b exp=1", o_out_valid); else n_pass++;
    n_total++; if (o_out_pc !== RESET_PC) $display("FAIL single_pc got=%h exp=%h", o_out_pc, RESET_PC); else n_pass++;
    n_total++; if (o_out_inst !== 32'h0000_0413) $display("FAIL single_inst got=%h exp=00000413", o_out_inst); else n_pass++;
    tick();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL single_empty got=%0b exp=0", o_out_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    fill_two();
    n_total++; if (o_in_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", o_in_ready); else n_pass++;
    i_in_valid = 1; i_in_pc = RESET_PC + 8; i_in_inst = 32'h1111_0003;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (o_in_ready !== 1'b0) $display("FAIL held_ready cyc=%0d got=%0b exp=0", k, o_in_ready); else n_pass++;
      n_total++; if (o_out_pc !== RESET_PC) $display("FAIL held_head cyc=%0d got=%h exp=%h", k, o_out_pc, RESET_PC); else n_pass++;
`ifdef YSYX_24090003_IFID_PERF_EN
      n_total++; if (o_stall_cnt !== exp_stall) $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", k, o_stall_cnt, exp_stall); else n_pass++;
`endif
    end
    // Pop one while still offering: ready rises only the cycle after.
    i_out_ready = 1;
    tick();
    n_total++; if (o_in_ready !== 1'b1) $display("FAIL pop_full_ready got=%0b exp=1", o_in_ready); else n_pass++;
    n_total++; if (o_out_pc !== RESET_PC + 4) $display("FAIL pop_full_head got=%h exp=%h", o_out_pc, RESET_PC + 4); else n_pass++;
    i_in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL drain_empty got=%0b exp=0", o_out_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_drain_order();
    logic [31:0] outs[$];
    int idx = 0;
    int cyc = 0;
    while (outs.size() < 5 && cyc < 300) begin
      i_in_valid  = (idx < 5) && ($urandom_range(0, 3) != 0);
      i_in_pc     = RESET_PC + 32'(4 * idx);
      i_in_inst   = $urandom;
      i_out_ready = $urandom_range(0, 1);
      if (i_in_valid && o_in_ready) idx++;
      if (o_out_valid && i_out_ready) outs.push_back(o_out_pc);
      tick();
      cyc++;
    end
    idle_inputs();
    n_total++; if (outs.size() != 5) $display("FAIL drain_count got=%0d exp=5", outs.size()); else n_pass++;
    for (int k = 0; k < outs.size(); k++) begin
      n_total++;
      if (outs[k] !== RESET_PC + 32'(4 * k)) $display("FAIL drain_order idx=%0d got=%h exp=%h", k, outs[k], RESET_PC + 32'(4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_two();
    i_flush = 1; i_in_valid = 1; i_in_pc = RESET_PC + 32'h100; i_in_inst = 32'hdead_beef;
    tick();
    idle_inputs();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL flush_valid got=%0b exp=0", o_out_valid); else n_pass++;
    n_total++; if (o_in_ready !== 1'b1) $display("FAIL flush_ready got=%0b exp=1", o_in_ready); else n_pass++;
`ifdef YSYX_24090003_IFID_PERF_EN
    n_total++; if (o_flush_cnt !== 32'd1) $display("FAIL flush_cnt got=%0d exp=1", o_flush_cnt); else n_pass++;
`endif
    i_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (o_out_valid !== 1'b0) $display("FAIL flush_dropped cyc=%0d got=%0b exp=0", k, o_out_valid); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    fill_two();
    i_rst = 1; i_flush = 1; i_in_valid = 1; i_in_pc = RESET_PC + 32'h200;
    tick();
    i_rst = 0;
    idle_inputs();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%0b exp=0", o_out_valid); else n_pass++;
    n_total++; if (o_in_ready !== 1'b1) $display("FAIL rst_mid_ready got=%0b exp=1", o_in_ready); else n_pass++;
    n_total++; if (o_out_pc !== 32'h0) $display("FAIL rst_mid_pc got=%h exp=0", o_out_pc); else n_pass++;
    n_total++; if (o_out_inst !== 32'h0) $display("FAIL rst_mid_inst got=%h exp=0", o_out_inst); else n_pass++;
`ifdef YSYX_24090003_IFID_PERF_EN
    n_total++; if (o_stall_cnt !== 32'd0) $display("FAIL rst_mid_stall got=%0d exp=0", o_stall_cnt); else n_pass++;
    n_total++; if (o_flush_cnt !== 32'd0) $display("FAIL rst_mid_flush got=%0d exp=0", o_flush_cnt); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      i_in_valid  = $urandom_range(0, 1);
      i_in_pc     = $urandom;
      i_in_inst   = $urandom;
      i_out_ready = $urandom_range(0, 2) != 0;
      i_flush     = $urandom_range(0, 15) == 0;
      tick();
      n_total++;
      if (o_out_valid !== (q.size() != 0) || o_in_ready !== (q.size() < DEPTH)) begin
        if (errs++ < 8) $display("FAIL rand_hs cyc=%0d got v=%0b r=%0b exp v=%0b r=%0b",
                                 c, o_out_valid, o_in_ready, q.size() != 0, q.size() < DEPTH);
      end else if (q.size() != 0 && (o_out_pc !== q[0].pc || o_out_inst !== q[0].inst)) begin
        if (errs++ < 8) $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h",
                                 c, o_out_pc, o_out_inst, q[0].pc, q[0].inst);
      end else n_pass++;
    end
    idle_inputs();
`ifdef YSYX_24090003_IFID_PERF_EN
    n_total++; if (o_stall_cnt !== exp_stall) $display("FAIL rand_stall got=%0d exp=%0d", o_stall_cnt, exp_stall); else n_pass++;
    n_total++; if (o_flush_cnt !== exp_flush) $display("FAIL rand_flush got=%0d exp=%0d", o_flush_cnt, exp_flush); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_drain_order();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_if_id_buf.md
# ysyx_24090003_if_id_buf

Decoupling buffer between the instruction fetch stage and the decode stage. It accepts `{pc, inst}` pairs from fetch over a valid/ready handshake, holds them in a small in-order FIFO, and presents them to decode over a second valid/ready handshake. It also discards all buffered instructions on a control-flow redirect (flush). All outputs are registered, so no combinational path exists from `i_out_ready` to `o_in_ready`.

## Interface
- `DEPTH`, 2, number of entries; power of two, ≥2
- `XLEN`, 32, width of pc and instruction fields
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_in_valid`  in  1  fetch presents a valid pair
- `o_in_ready`  out  1  buffer can accept this cycle
- `i_in_pc`  in  XLEN  pc of fetched instruction
- `i_in_inst`  in  XLEN  fetched instruction word
- `o_out_valid`  out  1  head entry valid for decode
- `i_out_ready`  in  1  decode consumes head this cycle
- `o_out_pc`  out  XLEN  pc of head entry
- `o_out_inst`  out  XLEN  instruction of head entry
- `i_flush`  in  1  redirect; discard all contents
- `o_stall_cnt`  out  32  (only with perf macro) cycles with `i_in_valid && !o_in_ready`
- `o_flush_cnt`  out  32  (only with perf macro) cycles with `i_flush` high

## Operation
- Storage: DEPTH entries of `{pc, inst}`, a write pointer and a read pointer (each `$clog2(DEPTH)` bits, wrapping modulo DEPTH), and a count (0..DEPTH).
- Push: `i_in_valid && o_in_ready && !i_flush` writes the entry at the write pointer, then increments the write pointer.
- Pop: `o_out_valid && i_out_ready && !i_flush` increments the read pointer.
- Count update: +1 on push only, −1 on pop only, unchanged when push and pop occur together.
- `o_in_ready` is a register equal to `count_next < DEPTH`. Full means not ready, even if decode pops in the same cycle.
- `o_out_valid = (count != 0)`.
- `o_out_pc`/`o_out_inst` come from the head entry. They are don't-care when invalid, but must not be X after reset.
- Flush:
  - Next cycle: count=0, both pointers=0, `o_out_valid`=0, `o_in_ready`=1.
  - A push offered in the flush cycle is dropped.
  - A pop in the flush cycle does not count as a transfer.
- Boundary behaviour:
  - Empty with push and `i_out_ready` both high: no same-cycle bypass. The entry appears on the output next cycle.
  - Full with pop: count becomes DEPTH−1 and ready rises next cycle.
  - Pointer wrap at DEPTH−1 → 0 preserves FIFO order.
- Reset, and reset taking priority over flush:
  - Count=0, pointers=0, `o_out_valid`=0, `o_in_ready`=1.
  - Storage cleared to 0, so `o_out_pc`=0 and `o_out_inst`=0.
  - Perf counters cleared to 0.

## Timing
- Latency: an entry accepted at edge N is visible on `o_out_*` with `o_out_valid`=1 after edge N. The minimum is 1 cycle.
- Throughput: one transfer per cycle in steady state when `count` is between 1 and DEPTH−1.
- `o_in_ready` depends only on registered state. Fetch may advance its pc only when `i_in_valid && o_in_ready` is high.
- Output data is stable while `o_out_valid && !i_out_ready`.
- Flush takes effect at the edge where it is sampled high. Contents are invisible from the next cycle.

## Configuration
- `YSYX_24090003_IFID_PERF_EN` defined:
  - `o_stall_cnt` and `o_flush_cnt` exist.
  - Both are 32-bit free-running counters that wrap at 2^32.
  - Both clear on reset.
- Not defined: both ports and counters are absent. The rest of the behaviour is identical.

## Structure
- Shared package `ysyx_24090003_pkg`:
  - `XLEN`
  - reset pc constant `32'h8000_0000`
  - typedef `if_id_entry_t` (`{pc, inst}`)
- One sub-module, `ysyx_24090003_fifo_mem`: a DEPTH×width register array with a synchronous write port, an asynchronous read port, and a synchronous clear. Pointer, count and handshake logic stay in the top.

## Test plan
- Reset: hold `i_rst` 2 cycles → `o_out_valid`=0, `o_in_ready`=1, `o_out_pc`=0, `o_out_inst`=0.
- Single pass: push pc=0x80000000, inst=0x00000413 with `i_out_ready`=1 → output valid the next cycle with the same values; empty after the pop.
- Fill/backpressure: `i_out_ready`=0, push 0x80000000 and 0x80000004 → `o_in_ready`=0. The third offer (0x80000008) is held. With the perf macro, `o_stall_cnt` increments each held cycle.
- Drain order and wrap: push/pop 5 pcs, 0x80000000 to 0x80000010, with random ready → same order out, no loss or duplication.
- Flush: when full, assert `i_flush` with a simultaneous push of 0x80000100 → next cycle `o_out_valid`=0 and `o_in_ready`=1; 0x80000100 never appears. With the perf macro, `o_flush_cnt`=1.
- Reset mid-operation: when full, assert `i_rst` together with `i_flush` → same state as after reset; perf counters=0.
